l2reqfifo: RTL and testbench

Request queue directly upstream of the L2 tag pipeline. It accepts cache-line requests from the icache (reads only) and the dcache (reads and word writes), arbitrates between them, and buffers accepted requests in order. It presents them one at a time to the L2 tag stage through a valid/ready handshake.

---
 rtl/l2reqfifo.sv | 135 +++++++++++++
 tb/tb_l2reqfifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2reqfifo.sv
// Request queue in front of the L2 tag pipeline: arbitrates icache/dcache requests
// round-robin and buffers them in strict FIFO order behind a valid/ready handshake.
module l2reqfifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             icache_req_valid,
   input  logic [29:0]      icache_req_addr,
   output logic             l2reqfifo_icache_ready,
   input  logic             dcache_req_valid,
   input  logic [29:0]      dcache_req_addr,
   input  logic             dcache_req_wen,
   input  logic [3:0]       dcache_req_wmask,
   input  logic [31:0]      dcache_req_wdata,
   output logic             l2reqfifo_dcache_ready,
   output logic             l2reqfifo_valid,
   output logic             l2reqfifo_dcache,
   output logic [29:0]      l2reqfifo_addr,
   output logic             l2reqfifo_wen,
   output logic [3:0]       l2reqfifo_wmask,
   output logic [31:0]      l2reqfifo_wdata,
   input  logic             l2tag_l2reqfifo_ready,
   output logic [PTR_W:0]   l2reqfifo_count
);

   typedef struct packed {
      logic        dcache;
      logic [29:0] addr;
      logic        wen;
      logic [3:0]  wmask;
      logic [31:0] wdata;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           wentry;
   entry_t           head;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             rr_dcache_q, rr_dcache_d;  // 1: dcache wins the next contested cycle
   logic             full, empty, accept_ok;
   logic             grant_i, grant_d, contested;
   logic             push, pop;

   assign full      = (count_q == (PTR_W+1)'(DEPTH));
   assign empty     = (count_q == '0);
   // Reset gates the readies combinationally so they read 0 while rst is held low.
   assign accept_ok = rst & ~full;
   assign contested = icache_req_valid & dcache_req_valid;
   assign grant_d   = dcache_req_valid & (~icache_req_valid | rr_dcache_q);
   assign grant_i   = icache_req_valid & (~dcache_req_valid | ~rr_dcache_q);

   assign l2reqfifo_icache_ready = accept_ok & grant_i;
   assign l2reqfifo_dcache_ready = accept_ok & grant_d;

   assign push = l2reqfifo_icache_ready | l2reqfifo_dcache_ready;
   assign pop  = ~empty & l2tag_l2reqfifo_ready;

   always_comb begin
      wentry = '0;
      if (grant_d) begin
         wentry.dcache = 1'b1;
         wentry.addr   = dcache_req_addr;
         wentry.wen    = dcache_req_wen;
         wentry.wmask  = dcache_req_wmask;
         wentry.wdata  = dcache_req_wdata;
      end else begin
         wentry.addr   = icache_req_addr;
      end
   end

   always_comb begin
      rptr_d      = rptr_q;
      wptr_d      = wptr_q;
      count_d     = count_q;
      rr_dcache_d = rr_dcache_q;
      if (push) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
         rptr_d = rptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
      if (push && contested) begin
         rr_dcache_d = grant_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rptr_q      <= '0;
         wptr_q      <= '0;
         count_q     <= '0;
         rr_dcache_q <= 1'b1;
      end else begin
         rptr_q      <= rptr_d;
         wptr_q      <= wptr_d;
         count_q     <= count_d;
         rr_dcache_q <= rr_dcache_d;
      end
   end

   // Storage is intentionally not reset; contents are meaningless while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= wentry;
      end
   end

   assign head            = mem_q[rptr_q];
   assign l2reqfifo_valid = ~empty;
   assign l2reqfifo_count = count_q;

   always_comb begin
      l2reqfifo_dcache = 1'b0;
      l2reqfifo_addr   = '0;
      l2reqfifo_wen    = 1'b0;
      l2reqfifo_wmask  = '0;
      l2reqfifo_wdata  = '0;
      if (!empty) begin
         l2reqfifo_dcache = head.dcache;
         l2reqfifo_addr   = head.addr;
         l2reqfifo_wen    = head.wen;
         l2reqfifo_wmask  = head.wmask;
         l2reqfifo_wdata  = head.wdata;
      end
   end

endmodule

// File: tb/tb_l2reqfifo.sv
// Directed bench for l2reqfifo: a vector table for arbitration/ordering plus
// hand-written sequences for latency, streaming at count=1 and mid-run reset.
module tb_l2reqfifo;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        iv = 1'b0;
   logic [29:0] ia = '0;
   logic        irdy;
   logic        dv = 1'b0;
   logic [29:0] da = '0;
   logic        dwen = 1'b0;
   logic [3:0]  dmask = '0;
   logic [31:0] ddata = '0;
   logic        drdy;
   logic        ovalid, odc, owen;
   logic [29:0] oaddr;
   logic [3:0]  omask;
   logic [31:0] odata;
   logic        tready = 1'b0;
   logic [2:0]  ocount;

   int errors = 0;
   int checks = 0;

   l2reqfifo #(.DEPTH(4), .PTR_W(2)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .icache_req_valid       (iv),
      .icache_req_addr        (ia),
      .l2reqfifo_icache_ready (irdy),
      .dcache_req_valid       (dv),
      .dcache_req_addr        (da),
      .dcache_req_wen         (dwen),
      .dcache_req_wmask       (dmask),
      .dcache_req_wdata       (ddata),
      .l2reqfifo_dcache_ready (drdy),
      .l2reqfifo_valid        (ovalid),
      .l2reqfifo_dcache       (odc),
      .l2reqfifo_addr         (oaddr),
      .l2reqfifo_wen          (owen),
      .l2reqfifo_wmask        (omask),
      .l2reqfifo_wdata        (odata),
      .l2tag_l2reqfifo_ready  (tready),
      .l2reqfifo_count        (ocount)
   );

   always #5 clk = ~clk;

   // Per-vector request payloads, derived from the vector index k.
   function automatic logic [29:0] iaddr_f(int k); return 30'h100 + 30'(k); endfunction
   function automatic logic [29:0] daddr_f(int k); return 30'h200 + 30'(k); endfunction
   function automatic logic dwen_f(int k); return (k % 2) == 1; endfunction
   function automatic logic [3:0] dmask_f(int k); return 4'(k - 1); endfunction
   function automatic logic [31:0] ddata_f(int k); return 32'hD000_0000 + 32'(k); endfunction

   // src: 0 = queue empty, 1 = head is icache request k, 2 = head is dcache request k
   typedef struct {
      bit iv, dv, rdy;
      bit exp_ir, exp_dr;
      int exp_cnt, exp_src, exp_k;
   } vec_t;

   vec_t tbl[22];

   function automatic vec_t mkv(bit v_i, bit v_d, bit r, bit e_ir, bit e_dr,
                                int cnt, int src, int k);
      vec_t v;
      v.iv = v_i; v.dv = v_d; v.rdy = r; v.exp_ir = e_ir; v.exp_dr = e_dr;
      v.exp_cnt = cnt; v.exp_src = src; v.exp_k = k;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_head(input string name, input bit dc, input logic [29:0] a,
                           input bit w, input logic [3:0] m, input logic [31:0] d);
      chk({name, ".valid"}, 64'(ovalid), 64'(1'b1));
      chk({name, ".dcache"}, 64'(odc), 64'(dc));
      chk({name, ".addr"}, 64'(oaddr), 64'(a));
      chk({name, ".wen"}, 64'(owen), 64'(w));
      chk({name, ".wmask"}, 64'(omask), 64'(m));
      chk({name, ".wdata"}, 64'(odata), 64'(d));
   endtask

   task automatic idle_inputs();
      iv = 1'b0; dv = 1'b0; tready = 1'b0;
      ia = '0; da = '0; dwen = 1'b0; dmask = '0; ddata = '0;
   endtask

   initial begin
      tbl[0]  = mkv(1, 0, 0, 1, 0, 0, 0, 0);
      tbl[1]  = mkv(1, 0, 0, 1, 0, 1, 1, 0);
      tbl[2]  = mkv(1, 0, 0, 1, 0, 2, 1, 0);
      tbl[3]  = mkv(1, 1, 0, 0, 1, 3, 1, 0);
      tbl[4]  = mkv(1, 1, 1, 0, 0, 4, 1, 0);
      tbl[5]  = mkv(1, 1, 0, 1, 0, 3, 1, 1);
      tbl[6]  = mkv(0, 0, 1, 0, 0, 4, 1, 1);
      tbl[7]  = mkv(0, 0, 1, 0, 0, 3, 1, 2);
      tbl[8]  = mkv(0, 0, 1, 0, 0, 2, 2, 3);
      tbl[9]  = mkv(0, 0, 1, 0, 0, 1, 1, 5);
      tbl[10] = mkv(0, 0, 0, 0, 0, 0, 0, 0);
      tbl[11] = mkv(1, 1, 0, 0, 1, 0, 0, 0);
      tbl[12] = mkv(1, 1, 0, 1, 0, 1, 2, 11);
      tbl[13] = mkv(1, 1, 0, 0, 1, 2, 2, 11);
      tbl[14] = mkv(1, 1, 0, 1, 0, 3, 2, 11);
      tbl[15] = mkv(1, 1, 0, 0, 0, 4, 2, 11);
      tbl[16] = mkv(0, 1, 1, 0, 0, 4, 2, 11);
      tbl[17] = mkv(0, 1, 1, 0, 1, 3, 1, 12);
      tbl[18] = mkv(0, 0, 1, 0, 0, 3, 2, 13);
      tbl[19] = mkv(0, 0, 1, 0, 0, 2, 1, 14);
      tbl[20] = mkv(0, 0, 1, 0, 0, 1, 2, 17);
      tbl[21] = mkv(0, 0, 0, 0, 0, 0, 0, 0);

      // Reset state: every output low even with both sources requesting.
      iv = 1'b1; dv = 1'b1; ia = 30'h1; da = 30'h2; tready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst.irdy", 64'(irdy), 64'd0);
      chk("rst.drdy", 64'(drdy), 64'd0);
      chk("rst.valid", 64'(ovalid), 64'd0);
      chk("rst.count", 64'(ocount), 64'd0);
      chk("rst.head", {odc, oaddr, owen, omask}, 64'd0);
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;

      // Single dcache write: one-cycle latency, head stable while not taken.
      @(negedge clk);
      dv = 1'b1; da = 30'h400; dwen = 1'b1; dmask = 4'b0011; ddata = 32'hDEADBEEF;
      #1;
      chk("t1.drdy", 64'(drdy), 64'd1);
      chk("t1.valid_pre", 64'(ovalid), 64'd0);
      @(negedge clk);
      idle_inputs();
      for (int c = 0; c < 5; c++) begin
         #1;
         chk_head($sformatf("t1.hold%0d", c), 1'b1, 30'h400, 1'b1, 4'b0011, 32'hDEADBEEF);
         chk($sformatf("t1.count%0d", c), 64'(ocount), 64'd1);
         @(negedge clk);
      end
      tready = 1'b1;
      @(negedge clk);
      tready = 1'b0;
      #1;
      chk("t1.valid_post", 64'(ovalid), 64'd0);
      chk("t1.count_post", 64'(ocount), 64'd0);

      // Vector table: arbitration from reset state, full behaviour, ordering.
      for (int v = 0; v < 22; v++) begin
         @(negedge clk);
         iv = tbl[v].iv; ia = iaddr_f(v);
         dv = tbl[v].dv; da = daddr_f(v);
         dwen = dwen_f(v); dmask = dmask_f(v); ddata = ddata_f(v);
         tready = tbl[v].rdy;
         #1;
         chk($sformatf("v%0d.irdy", v), 64'(irdy), 64'(tbl[v].exp_ir));
         chk($sformatf("v%0d.drdy", v), 64'(drdy), 64'(tbl[v].exp_dr));
         chk($sformatf("v%0d.count", v), 64'(ocount), 64'(tbl[v].exp_cnt));
         if (tbl[v].exp_src == 0) begin
            chk($sformatf("v%0d.valid", v), 64'(ovalid), 64'd0);
         end else if (tbl[v].exp_src == 1) begin
            chk_head($sformatf("v%0d", v), 1'b0, iaddr_f(tbl[v].exp_k), 1'b0, 4'h0, 32'h0);
         end else begin
            chk_head($sformatf("v%0d", v), 1'b1, daddr_f(tbl[v].exp_k),
                     dwen_f(tbl[v].exp_k), dmask_f(tbl[v].exp_k), ddata_f(tbl[v].exp_k));
         end
      end
      @(negedge clk);
      idle_inputs();

      // Streaming at count=1: 21 pushes wrap the 4-entry pointers five times.
      iv = 1'b1; ia = 30'h3000; tready = 1'b1;
      #1;
      chk("t4.irdy0", 64'(irdy), 64'd1);
      chk("t4.valid0", 64'(ovalid), 64'd0);
      for (int j = 1; j <= 20; j++) begin
         @(negedge clk);
         ia = 30'h3000 + 30'(j);
         #1;
         chk($sformatf("t4.addr%0d", j), 64'(oaddr), 64'(30'h3000 + 30'(j - 1)));
         chk($sformatf("t4.count%0d", j), 64'(ocount), 64'd1);
      end
      @(negedge clk);
      iv = 1'b0;
      #1;
      chk("t4.last", 64'(oaddr), 64'(30'h3014));
      chk("t4.last_count", 64'(ocount), 64'd1);
      @(negedge clk);
      #1;
      chk("t4.drained", 64'(ovalid), 64'd0);
      idle_inputs();

      // Asynchronous reset with 3 entries queued, then a fresh request.
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         iv = 1'b1; ia = 30'h500 + 30'(n);
      end
      @(negedge clk);
      ia = 30'h5FF;
      #1;
      chk("t5.count_pre", 64'(ocount), 64'd3);
      #2;
      rst = 1'b0;
      #1;
      chk("t5.valid_rst", 64'(ovalid), 64'd0);
      chk("t5.count_rst", 64'(ocount), 64'd0);
      chk("t5.irdy_rst", 64'(irdy), 64'd0);
      @(negedge clk);
      iv = 1'b0;
      #2;
      rst = 1'b1;
      @(negedge clk);
      iv = 1'b1; ia = 30'h600;
      #1;
      chk("t5.irdy_new", 64'(irdy), 64'd1);
      chk("t5.valid_new_pre", 64'(ovalid), 64'd0);
      @(negedge clk);
      iv = 1'b0; tready = 1'b1;
      #1;
      chk_head("t5.new", 1'b0, 30'h600, 1'b0, 4'h0, 32'h0);
      chk("t5.count_new", 64'(ocount), 64'd1);
      @(negedge clk);
      tready = 1'b0;
      #1;
      chk("t5.no_stale", 64'(ovalid), 64'd0);
      chk("t5.count_end", 64'(ocount), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
